// File: rtl/grey_pkg.sv
// Shared constants and types for the grey counter sequencer.
// Digit geometry, FSM states and display bus bit positions.
package grey_pkg;

    localparam int NDIG = 12;
    localparam int DW = 5;
    localparam int PW = NDIG * DW;

    localparam int IO_FRAME = 5;
    localparam int IO_FROZEN = 6;
    localparam int IO_BUSY = 7;

    typedef enum logic [1:0] {
        SCAN,
        SHIFT,
        APPLY
    } seq_state_t;

endpackage

// File: rtl/grey_seq_if.sv
// Pin-side and counter-side signals of the grey sequencer.
// master drives pins and live digits; slave is the sequencer.
interface grey_seq_if;
    import grey_pkg::*;

    logic          DIN;
    logic          LOAD;
    logic          FREEZE;
    logic [PW-1:0] DIGITS;
    logic [PW-1:0] INIT;
    logic          INIT_STB;
    logic [5:0]    SEL;
    logic [7:0]    IO_OUT;

    modport master (
        output DIN,
        output LOAD,
        output FREEZE,
        output DIGITS,
        input  INIT,
        input  INIT_STB,
        input  SEL,
        input  IO_OUT
    );

    modport slave (
        input  DIN,
        input  LOAD,
        input  FREEZE,
        input  DIGITS,
        output INIT,
        output INIT_STB,
        output SEL,
        output IO_OUT
    );

endinterface

// File: rtl/grey_seq_scan.sv
// Digit scanner: dwell counter, digit index with wrap, select output.
// restart forces the scan back to digit 0 with a fresh dwell.
module grey_seq_scan
    import grey_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    output logic [3:0] idx,
    output logic [5:0] sel
);

    localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWW-1:0] DLAST = DWW'(DWELL - 1);
    localparam logic [3:0] ILAST = 4'(NDIG - 1);

    logic [DWW-1:0] dwell;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dwell <= '0;
            idx   <= '0;
        end else if (restart) begin
            dwell <= '0;
            idx   <= '0;
        end else if (dwell == DLAST) begin
            dwell <= '0;
            idx   <= (idx == ILAST) ? 4'd0 : idx + 4'd1;
        end else begin
            dwell <= dwell + DWW'(1);
        end
    end

    assign sel = {2'b00, idx};

endmodule

// File: rtl/grey_seq.sv
// Sequencer for the 12-digit grey counter: serial preset, scan, display.
// Snapshot freeze is built only with GREY_SEQ_FREEZE_EN defined.
module grey_seq
    import grey_pkg::*;
#(
    parameter int DWELL = 4
) (
    input logic       CLK,
    input logic       RST,
    grey_seq_if.slave bus
);

    seq_state_t    state;
    logic [5:0]    bitcnt;
    logic [PW-2:0] shift_q;
    logic [PW-1:0] shift_d;
    logic [PW-1:0] init_q;
    logic          stb_q;
    logic [7:0]    io_q;
    logic [3:0]    idx;
    logic [PW-1:0] src;
    logic          frozen;

    grey_seq_scan #(
        .DWELL(DWELL)
    ) u_scan (
        .clk    (CLK),
        .rst_n  (RST),
        .restart(state == APPLY),
        .idx    (idx),
        .sel    (bus.SEL)
    );

`ifdef GREY_SEQ_FREEZE_EN
    logic [PW-1:0] snap_q;
    logic          frz_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            snap_q <= '0;
            frz_q  <= 1'b0;
        end else begin
            frz_q <= bus.FREEZE;
            if (bus.FREEZE && !frz_q)
                snap_q <= bus.DIGITS;
        end
    end

    // On the rising cycle itself the snapshot is not loaded yet
    assign src = (bus.FREEZE && frz_q) ? snap_q : bus.DIGITS;
    assign frozen = bus.FREEZE;
`else
    logic unused_freeze;

    assign unused_freeze = bus.FREEZE;
    assign src = bus.DIGITS;
    assign frozen = 1'b0;
`endif

    assign shift_d = {shift_q, bus.DIN};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= SCAN;
            bitcnt  <= '0;
            shift_q <= '0;
            init_q  <= '0;
            stb_q   <= 1'b0;
            io_q    <= '0;
        end else begin
            io_q[DW-1:0]     <= src[int'(idx)*DW +: DW];
            io_q[IO_FRAME]   <= (idx == 4'd0);
            io_q[IO_FROZEN]  <= frozen;
            unique case (state)
                SCAN: begin
                    stb_q <= 1'b0;
                    if (bus.LOAD) begin
                        state          <= SHIFT;
                        bitcnt         <= '0;
                        io_q[IO_BUSY]  <= 1'b1;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d[PW-2:0];
                    bitcnt  <= bitcnt + 6'd1;
                    // Final bit goes straight into INIT for APPLY
                    if (bitcnt == 6'(PW - 1)) begin
                        state          <= APPLY;
                        bitcnt         <= '0;
                        init_q         <= shift_d;
                        stb_q          <= 1'b1;
                        io_q[IO_BUSY]  <= 1'b0;
                    end
                end
                APPLY: begin
                    state <= SCAN;
                    stb_q <= 1'b0;
                end
                default: begin
                    state <= SCAN;
                    stb_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.INIT = init_q;
    assign bus.INIT_STB = stb_q;
    assign bus.IO_OUT = io_q;

endmodule
